// File: rtl/des_select_ctrl.sv
// Configuration front end for the design multiplexer: receives an 8-bit
// serial frame on three asynchronous pins, validates it, commits the
// selection and issues a timed reset pulse to the designs.
module des_select_ctrl #(
    parameter int         RST_CYCLES   = 4,
    parameter logic [5:0] DEFAULT_SEL  = 6'd0,
    parameter logic       DEFAULT_HOLD = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_sclk,
    input  logic       cfg_sdata,
    input  logic       cfg_latch,
    output logic [5:0] des_sel,
    output logic       hold_if_not_sel,
    output logic       design_reset,
    output logic       cfg_busy,
    output logic       cfg_err
);

    localparam int             CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0]  RST_LOAD = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, SWITCH} state_t;

    state_t        state, state_d;
    logic [CW-1:0] rst_cnt, rst_cnt_d;
    logic [2:0]    sclk_sync, latch_sync;
    logic [1:0]    sdata_sync;
    logic [7:0]    shreg;
    logic [3:0]    bit_cnt;
    logic          len_ok;
    logic          sclk_rise, latch_rise, sdata_s;
    logic          shift_en, commit, frame_ok;

    // Two flops of metastability filtering per pin; the third flop on
    // sclk/latch gives the previous value for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync  <= '0;
            latch_sync <= '0;
            sdata_sync <= '0;
        end else begin
            sclk_sync  <= {sclk_sync[1:0], cfg_sclk};
            latch_sync <= {latch_sync[1:0], cfg_latch};
            sdata_sync <= {sdata_sync[0], cfg_sdata};
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign latch_rise = latch_sync[1] & ~latch_sync[2];
    assign sdata_s    = sdata_sync[1];

    // Latch beats a coincident sclk edge; nothing shifts outside IDLE.
    assign shift_en = (state == IDLE) && sclk_rise && !latch_rise;
    // Even parity over the whole frame means the XOR of all 8 bits is 0.
    assign frame_ok = len_ok && !(^shreg);

    // Next-state logic and pulse down counter.
    always_comb begin
        state_d   = state;
        rst_cnt_d = rst_cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (latch_rise) state_d = CHECK;
            end
            CHECK: begin
                if (frame_ok) begin
                    commit    = 1'b1;
                    state_d   = SWITCH;
                    rst_cnt_d = RST_LOAD;
                end else begin
                    state_d   = IDLE;
                end
            end
            SWITCH: begin
                if (rst_cnt == '0) state_d = IDLE;
                else               rst_cnt_d = rst_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset parks the FSM in SWITCH with a full count so
    // the design reset pulse extends past reset release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= SWITCH;
            rst_cnt <= RST_LOAD;
        end else begin
            state   <= state_d;
            rst_cnt <= rst_cnt_d;
        end
    end

    // Shift register and saturating bit counter. The length verdict is
    // captured at the latch edge because the counter is cleared there.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            len_ok  <= 1'b0;
        end else begin
            if (shift_en) shreg <= {shreg[6:0], sdata_s};
            if (state == IDLE && latch_rise) len_ok <= (bit_cnt == 4'd8);
            if (latch_rise || commit)
                bit_cnt <= '0;
            else if (shift_en && bit_cnt != 4'hF)
                bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Committed selection and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            des_sel         <= DEFAULT_SEL;
            hold_if_not_sel <= DEFAULT_HOLD;
            cfg_err         <= 1'b0;
        end else if (state == CHECK) begin
            if (frame_ok) begin
                des_sel         <= shreg[5:0];
                hold_if_not_sel <= shreg[6];
                cfg_err         <= 1'b0;
            end else begin
                cfg_err         <= 1'b1;
            end
        end
    end

    assign design_reset = reset || (state == SWITCH);
    assign cfg_busy     = design_reset;

endmodule

// File: tb/tb_des_select_ctrl.sv
// Scoreboard bench for des_select_ctrl: stimulus pushes the expected reset
// pulse for every committing frame; a negedge monitor pops on each
// design_reset rise and checks selection, error flag, start cycle, length.
module tb_des_select_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_sclk = 1'b0;
    logic       cfg_sdata = 1'b0;
    logic       cfg_latch = 1'b0;
    logic [5:0] des_sel;
    logic       hold_if_not_sel;
    logic       design_reset;
    logic       cfg_busy;
    logic       cfg_err;

    des_select_ctrl #(
        .RST_CYCLES  (4),
        .DEFAULT_SEL (6'd0),
        .DEFAULT_HOLD(1'b1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_sclk       (cfg_sclk),
        .cfg_sdata      (cfg_sdata),
        .cfg_latch      (cfg_latch),
        .des_sel        (des_sel),
        .hold_if_not_sel(hold_if_not_sel),
        .design_reset   (design_reset),
        .cfg_busy       (cfg_busy),
        .cfg_err        (cfg_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int sel;
        int hold;
        int start;   // -1: start cycle not checked
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: one scoreboard entry per design_reset pulse.
    exp_t cur;
    bit   in_pulse = 0;
    bit   have_cur = 0;
    int   rise_cyc = 0;
    always @(negedge clock) begin
        if (design_reset === 1'b1 && !in_pulse) begin
            in_pulse = 1;
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                have_cur = 0;
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got pulse at cyc %0d, required none", cyc);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1;
                check("pulse_sel", 32'(des_sel), cur.sel);
                check("pulse_hold", 32'(hold_if_not_sel), cur.hold);
                check("pulse_err", 32'(cfg_err), 0);
                check("pulse_busy", 32'(cfg_busy), 1);
                if (cur.start >= 0) check("pulse_start", cyc, cur.start);
            end
        end else if (design_reset !== 1'b1 && in_pulse) begin
            in_pulse = 0;
            if (have_cur) check("pulse_len", cyc - rise_cyc, cur.len);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_sdata = v[i];
            cfg_sclk  = 1'b0;
            tick(2);
            cfg_sclk  = 1'b1;
            tick(3);
            cfg_sclk  = 1'b0;
            tick(2);
        end
    endtask

    task automatic push_exp(input int sel, input int hold, input int start, input int len);
        exp_t e;
        e.sel = sel; e.hold = hold; e.start = start; e.len = len;
        exp_q.push_back(e);
    endtask

    // Frame then latch; a committing frame must pulse 4 cycles after the
    // latch pin edge (3 sync cycles + CHECK) for 4 cycles.
    task automatic send_frame(input logic [31:0] v, input int n, input bit commits,
                              input int sel, input int hold);
        send_bits(v, n);
        tick(3);
        cfg_latch = 1'b1;
        if (commits) push_exp(sel, hold, cyc + 4, 4);
        tick(6);
        cfg_latch = 1'b0;
        tick(12);
    endtask

    task automatic check_outs(input string name, input int sel, input int hold, input int err);
        @(negedge clock);
        check({name, "_sel"}, 32'(des_sel), sel);
        check({name, "_hold"}, 32'(hold_if_not_sel), hold);
        check({name, "_err"}, 32'(cfg_err), err);
        check({name, "_busy"}, 32'(cfg_busy), 0);
    endtask

    int k;

    initial begin
        // Reset for 3 edges: 2 sampled negedges in reset + 4 after release.
        push_exp(0, 1, 1, 6);
        tick(3);
        reset = 1'b0;
        tick(8);
        check_outs("after_reset", 0, 1, 0);

        // Valid 0xC5: sel 5, hold 1.
        send_frame(32'hC5, 8, 1, 5, 1);
        check_outs("c5", 5, 1, 0);

        // Bad parity 0x45: rejected, no pulse.
        send_frame(32'h45, 8, 0, 0, 0);
        check_outs("bad_parity", 5, 1, 1);

        // Valid 0x00 clears the error.
        send_frame(32'h00, 8, 1, 0, 0);
        check_outs("zero", 0, 0, 0);

        // Same frame again still pulses.
        send_frame(32'h00, 8, 1, 0, 0);
        check_outs("repeat", 0, 0, 0);

        // Short frame.
        send_frame(32'h45, 7, 0, 0, 0);
        check_outs("short7", 0, 0, 1);

        // 10 bits whose last 8 form a valid frame.
        send_frame(32'h0C5, 10, 0, 0, 0);
        check_outs("long10", 0, 0, 1);

        // 24 bits: a wrapping counter would read 8 here.
        send_frame(32'h0000C5, 24, 0, 0, 0);
        check_outs("long24", 0, 0, 1);

        // Coincident sclk and latch after 0xAA: extra bit is dropped.
        send_bits(32'hAA, 8);
        tick(3);
        cfg_sdata = 1'b1;
        cfg_sclk  = 1'b1;
        cfg_latch = 1'b1;
        k = cyc;
        push_exp(42, 0, k + 4, 4);
        // sclk rises landing inside SWITCH must be ignored.
        tick(1); cfg_sclk = 1'b0;
        tick(1); cfg_sclk = 1'b1;
        tick(1); cfg_sclk = 1'b0;
        tick(1); cfg_sclk = 1'b1;
        tick(1); cfg_sclk = 1'b0;
        tick(1); cfg_latch = 1'b0;
        tick(12);
        check_outs("same_cycle", 42, 0, 0);

        // Next frame must count from zero.
        send_frame(32'hC5, 8, 1, 5, 1);
        check_outs("after_switch_edges", 5, 1, 0);

        // Commit sel 9, then reset in the 2nd SWITCH cycle: one merged
        // pulse of 1 + 2 + 4 sampled cycles.
        send_bits(32'h09, 8);
        tick(3);
        cfg_latch = 1'b1;
        k = cyc;
        push_exp(9, 0, k + 4, 7);
        tick(5);
        reset = 1'b1;
        tick(1);
        @(negedge clock);
        check("mid_reset_sel", 32'(des_sel), 0);
        check("mid_reset_hold", 32'(hold_if_not_sel), 1);
        check("mid_reset_err", 32'(cfg_err), 0);
        check("mid_reset_drst", 32'(design_reset), 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cfg_latch = 1'b0;
        tick(12);
        check_outs("post_reset", 0, 1, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

endmodule

// File: doc/des_select_ctrl.md
Name: des_select_ctrl

Overview:
- Upstream configuration stage for the design multiplexer. Receives a slow serial configuration frame on three chip pins, then synchronizes, validates and commits it.
- Drives the multiplexer's `des_sel[5:0]` and `hold_if_not_sel` inputs.
- On every committed change, and after chip reset, issues a timed design reset pulse so the newly selected design starts from a clean state.

Parameters:
- `RST_CYCLES`, 4: length in clock cycles of the `design_reset` pulse after a commit or after reset release. Must be at least 1.
- `DEFAULT_SEL`, 6'd0: `des_sel` value at reset.
- `DEFAULT_HOLD`, 1'b1: `hold_if_not_sel` value at reset.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cfg_sclk`  in  1  asynchronous serial clock pin; data is sampled on its rising edge
- `cfg_sdata`  in  1  asynchronous serial data pin, MSB first
- `cfg_latch`  in  1  asynchronous latch pin; a rising edge ends the frame
- `des_sel`  out  6  selected design index, to the multiplexer
- `hold_if_not_sel`  out  1  hold-unselected flag, to the multiplexer
- `design_reset`  out  1  reset for the designs; ORed with `reset` upstream of the multiplexer
- `cfg_busy`  out  1  high while a reset pulse is in progress
- `cfg_err`  out  1  sticky flag: last frame was rejected

Behaviour:
- Interface: one clock, `clock`. Reset is `reset`, synchronous and active-high.
- Synchronization:
  - Each `cfg_*` pin passes through 2 flops, plus a third flop on `sclk` and `latch` for edge detection.
  - Pin edge to internal action: exactly 3 cycles.
- Frame format, 8 bits:
  - [7] even parity over [6:0]
  - [6] hold
  - [5:0] sel
- Shift register: 8 bits, `shreg <= {shreg[6:0], sdata_s}` on each detected `sclk` rise.
- Bit counter:
  - 4 bits, saturating at 15.
  - Cleared on any latch edge, on commit, and on reset.
- FSM states: `IDLE`, `CHECK`, `SWITCH`.
  - `IDLE`:
    - `sclk` edges shift and count.
    - A latch edge moves to `CHECK`.
    - If `sclk` and latch edges are detected in the same cycle, the latch wins and that `sclk` edge is dropped.
  - `CHECK`, one cycle:
    - Valid frame = bit count exactly 8 and `^shreg == 0`.
    - If valid: `des_sel <= shreg[5:0]`, `hold_if_not_sel <= shreg[6]`, `cfg_err <= 0`, go to `SWITCH`.
    - If not valid: `cfg_err <= 1`, outputs unchanged, return to `IDLE`.
  - `SWITCH`:
    - `design_reset = 1` and `cfg_busy = 1` for exactly `RST_CYCLES` cycles, counted by a down counter; then go to `IDLE`.
    - Edges detected during `SWITCH` are dropped.
    - The bit counter stays 0 during `SWITCH`.
- Latency: new `des_sel` is visible 1 cycle after the latch edge is detected. `design_reset` rises in that same cycle.
- A committed frame identical to the current selection still generates the full reset pulse.
- Reset, applied at any time including mid-frame or mid-`SWITCH`:
  - `des_sel = DEFAULT_SEL`, `hold_if_not_sel = DEFAULT_HOLD`, `cfg_err = 0`.
  - Shift register, counters and synchronizer flops cleared.
  - `design_reset = 1` and `cfg_busy = 1` while reset is held.
  - On release, the FSM enters `SWITCH` with a full `RST_CYCLES` count, so `design_reset` stays high `RST_CYCLES` more cycles.
- Overlength frames (count saturated at 15, or 9–14 bits) and shortened frames are rejected at `CHECK`.

Test Plan:
- Reset held 3 cycles, then released: `des_sel = 0`, `hold_if_not_sel = 1`, `cfg_err = 0`. `design_reset` and `cfg_busy` are high during reset plus 4 cycles, then 0.
- Shift 0xC5 (sel = 5, hold = 1, parity = 1), then latch: 3 cycles after the latch edge the FSM is in `CHECK`. Next cycle `des_sel = 5`, `hold = 1`, and `design_reset` is high for exactly 4 cycles.
- Shift 0x45 (bad parity), then latch: `cfg_err = 1`, `des_sel` and `hold` unchanged, no `design_reset` pulse. A following valid 0x00 clears `cfg_err` and gives `des_sel = 0`, `hold = 0`.
- Shift 7 bits, then latch → `cfg_err = 1`. Shift 10 bits, then latch → `cfg_err = 1`. Outputs unchanged in both cases.
- `sclk` rise and `latch` rise on the same cycle after 8 valid bits: the frame commits and the extra bit is not shifted. Edges sent during `SWITCH` are dropped and the next frame counts from 0.
- Assert reset during the 2nd cycle of a `SWITCH` pulse after committing sel = 9: outputs return to `DEFAULT_SEL` / `DEFAULT_HOLD`, then a full 4-cycle pulse follows release.
